// File: rtl/univ_shift_reg_pkg.sv
// Shared constants for the universal shift register: mode encodings and legal width range.
// No logic here; imported by the datapath and the register wrapper.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASHR = 3'b110;
  localparam logic [2:0] MODE_CPL  = 3'b111;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/univ_shift_reg_next.sv
// Next-state mux of the universal shift register; purely combinational, zero latency.
// Only the inputs the selected mode needs reach nxt_o, so X on the others is harmless.
module usr_next
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             ser_lsb_i,
  input  logic             ser_msb_i,
  output logic [WIDTH-1:0] nxt_o
);

  always_comb begin
    nxt_o = q_i;
    case (mode_i)
      MODE_HOLD: nxt_o = q_i;
      MODE_SHL:  nxt_o = {q_i[WIDTH-2:0], ser_lsb_i};
      MODE_SHR:  nxt_o = {ser_msb_i, q_i[WIDTH-1:1]};
      MODE_ROL:  nxt_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROR:  nxt_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_LOAD: nxt_o = d_i;
      MODE_ASHR: nxt_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      MODE_CPL:  nxt_o = ~q_i;
      default:   nxt_o = q_i;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/shift/rotate/load/complement, async active-high reset.
// One clock from inputs to q; qb, serial taps and zero are combinational from q.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_lsb_in,
  input  logic             ser_msb_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             ser_msb_out,
  output logic             ser_lsb_out,
  output logic             zero
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("univ_shift_reg: WIDTH out of range 2..64");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  usr_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .mode_i    (mode),
    .q_i       (q_q),
    .d_i       (d),
    .ser_lsb_i (ser_lsb_in),
    .ser_msb_i (ser_msb_in),
    .nxt_o     (q_d)
  );

  // sclr outranks en so a stalled pipeline can still be cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else if (sclr) begin
      q_q <= RST_VAL;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  assign q           = q_q;
  assign qb          = ~q_q;
  assign ser_msb_out = q_q[WIDTH-1];
  assign ser_lsb_out = q_q[0];
  assign zero        = (q_q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg at WIDTH 8, 2 and 64.
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam logic [7:0]  R8  = 8'hA5;
  localparam logic [1:0]  R2  = 2'b10;
  localparam logic [63:0] R64 = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sclr, sl, sm, en8, en2, en64;
  logic [2:0] mode;
  logic [7:0]  d8,  q8,  qb8;
  logic [1:0]  d2,  q2,  qb2;
  logic [63:0] d64, q64, qb64;
  logic msb8, lsb8, z8, msb2, lsb2, z2, msb64, lsb64, z64;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(R8)) u8 (
    .clk(clk), .rst(rst), .en(en8), .sclr(sclr), .mode(mode), .d(d8),
    .ser_lsb_in(sl), .ser_msb_in(sm), .q(q8), .qb(qb8),
    .ser_msb_out(msb8), .ser_lsb_out(lsb8), .zero(z8));
  univ_shift_reg #(.WIDTH(2), .RST_VAL(R2)) u2 (
    .clk(clk), .rst(rst), .en(en2), .sclr(sclr), .mode(mode), .d(d2),
    .ser_lsb_in(sl), .ser_msb_in(sm), .q(q2), .qb(qb2),
    .ser_msb_out(msb2), .ser_lsb_out(lsb2), .zero(z2));
  univ_shift_reg #(.WIDTH(64), .RST_VAL(R64)) u64 (
    .clk(clk), .rst(rst), .en(en64), .sclr(sclr), .mode(mode), .d(d64),
    .ser_lsb_in(sl), .ser_msb_in(sm), .q(q64), .qb(qb64),
    .ser_msb_out(msb64), .ser_lsb_out(lsb64), .zero(z64));

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];
  logic [63:0] exp;

  function automatic logic [63:0] q_of(input int w);
    if (w == 2) return {62'b0, q2};
    if (w == 64) return q64;
    return {56'b0, q8};
  endfunction

  function automatic logic [63:0] rst_of(input int w);
    if (w == 2) return {62'b0, R2};
    if (w == 64) return R64;
    return {56'b0, R8};
  endfunction

  // Reference behaviour for a left shift at arbitrary width
  function automatic logic [63:0] shl_model(input int w, input logic [63:0] v, input logic b);
    logic [63:0] msk;
    msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((v << 1) | {63'b0, b}) & msk;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input int w);
    en8  = (w == 8);
    en2  = (w == 2);
    en64 = (w == 64);
  endtask

  task automatic pop_cmp8(input string name);
    exp = sb.pop_front();
    n_vec++;
    if (q8 !== exp[7:0]) begin
      n_err++;
      $display("FAIL %s: q=%h expected %h", name, q8, exp[7:0]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (q8 !== R8)      begin n_err++; $display("FAIL rst_q8: %h vs %h", q8, R8); end
    n_vec++; if (qb8 !== 8'h5A)  begin n_err++; $display("FAIL rst_qb8: %h vs 5a", qb8); end
    n_vec++; if (z8 !== 1'b0 || msb8 !== 1'b1 || lsb8 !== 1'b1)
      begin n_err++; $display("FAIL rst_flags8: z=%b msb=%b lsb=%b vs 0 1 1", z8, msb8, lsb8); end
    n_vec++; if (q2 !== R2 || qb2 !== 2'b01 || z2 !== 1'b0 || msb2 !== 1'b1 || lsb2 !== 1'b0)
      begin n_err++; $display("FAIL rst_w2: q=%b qb=%b z=%b msb=%b lsb=%b vs 10 01 0 1 0", q2, qb2, z2, msb2, lsb2); end
    n_vec++; if (q64 !== R64 || qb64 !== ~R64 || z64 !== 1'b0 || msb64 !== 1'b0 || lsb64 !== 1'b1)
      begin n_err++; $display("FAIL rst_w64: q=%h qb=%h z=%b msb=%b lsb=%b", q64, qb64, z64, msb64, lsb64); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_shift();
    select(8);
    mode = MODE_LOAD; d8 = 8'h81; sl = 1'bx; sm = 1'bx;
    sb.push_back(64'h81); cyc(); pop_cmp8("load81");
    mode = MODE_SHL; sl = 1'b1; d8 = 8'hxx;
    n_vec++; if (msb8 !== 1'b1) begin n_err++; $display("FAIL msb_tap_preshift: %b vs 1", msb8); end
    sb.push_back(64'h03); cyc(); pop_cmp8("shl");
    mode = MODE_SHR; sm = 1'b0; sl = 1'bx;
    sb.push_back(64'h01); cyc(); pop_cmp8("shr");
  endtask

  task automatic test_rotate_ashr();
    select(8);
    mode = MODE_LOAD; d8 = 8'h96;
    sb.push_back(64'h96); cyc(); pop_cmp8("load96");
    mode = MODE_ROL; d8 = 8'hxx; sl = 1'bx; sm = 1'bx;
    sb.push_back(64'h96);
    for (int i = 0; i < 8; i++) cyc();
    pop_cmp8("rol8x");
    mode = MODE_ROR;
    sb.push_back(64'h4B); cyc(); pop_cmp8("ror");
    mode = MODE_LOAD; d8 = 8'h90;
    sb.push_back(64'h90); cyc(); pop_cmp8("load90");
    mode = MODE_ASHR; d8 = 8'hxx;
    sb.push_back(64'hC8); cyc(); pop_cmp8("ashr1");
    sb.push_back(64'hE4); cyc(); pop_cmp8("ashr2");
  endtask

  task automatic test_priority();
    select(8);
    mode = MODE_LOAD; d8 = 8'h3C;
    sb.push_back(64'h3C); cyc(); pop_cmp8("load3c");
    en8 = 1'b0; mode = MODE_CPL;
    sb.push_back(64'h3C); cyc(); pop_cmp8("en0_hold");
    en8 = 1'b1;
    sb.push_back(64'hC3); cyc(); pop_cmp8("cpl");
    en8 = 1'b0; sclr = 1'b1;
    sb.push_back({56'b0, R8}); cyc(); pop_cmp8("sclr_en0");
    sclr = 1'b0; en8 = 1'b1; mode = MODE_LOAD; d8 = 8'h3C;
    sb.push_back(64'h3C); cyc(); pop_cmp8("reload3c");
    #2;
    sclr = 1'b1; rst = 1'b1;
    #1;
    n_vec++; if (q8 !== R8) begin n_err++; $display("FAIL sclr_rst_async: %h vs %h", q8, R8); end
    @(negedge clk);
    rst = 1'b0; sclr = 1'b0;
  endtask

  task automatic test_zero();
    select(8);
    mode = MODE_LOAD; d8 = 8'h00;
    sb.push_back(64'h00); cyc(); pop_cmp8("load00");
    n_vec++; if (z8 !== 1'b1) begin n_err++; $display("FAIL zero_set: %b vs 1", z8); end
    mode = MODE_SHL; sl = 1'b1; d8 = 8'hxx;
    sb.push_back(64'h01); cyc(); pop_cmp8("shl_from0");
    n_vec++; if (z8 !== 1'b0) begin n_err++; $display("FAIL zero_clr: %b vs 0", z8); end
  endtask

  task automatic test_async_mid(input int w);
    logic [63:0] m;
    select(w);
    mode = MODE_LOAD;
    d8 = 8'h5A; d2 = 2'b01; d64 = 64'hF0E1_D2C3_B4A5_9687;
    m = (w == 2) ? 64'h1 : ((w == 64) ? 64'hF0E1_D2C3_B4A5_9687 : 64'h5A);
    sb.push_back(m); cyc();
    exp = sb.pop_front();
    n_vec++; if (q_of(w) !== exp) begin n_err++; $display("FAIL mid_load_w%0d: %h vs %h", w, q_of(w), exp); end
    mode = MODE_SHL;
    for (int k = 0; k < 3; k++) begin
      sl = 1'($urandom_range(0, 1));
      m = shl_model(w, m, sl);
      sb.push_back(m); cyc();
      exp = sb.pop_front();
      n_vec++; if (q_of(w) !== exp) begin n_err++; $display("FAIL mid_shl_w%0d_%0d: %h vs %h", w, k, q_of(w), exp); end
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (q_of(w) !== rst_of(w)) begin n_err++; $display("FAIL mid_rst_w%0d: %h vs %h", w, q_of(w), rst_of(w)); end
    @(negedge clk);
    rst = 1'b0;
    m = rst_of(w);
    for (int k = 0; k < 3; k++) begin
      sl = 1'($urandom_range(0, 1));
      m = shl_model(w, m, sl);
      sb.push_back(m); cyc();
      exp = sb.pop_front();
      n_vec++; if (q_of(w) !== exp) begin n_err++; $display("FAIL resume_w%0d_%0d: %h vs %h", w, k, q_of(w), exp); end
    end
  endtask

  initial begin
    rst = 1'b0; sclr = 1'b0; sl = 1'b0; sm = 1'b0;
    en8 = 1'b0; en2 = 1'b0; en64 = 1'b0;
    mode = MODE_HOLD; d8 = '0; d2 = '0; d64 = '0;
    test_reset();
    test_load_shift();
    test_rotate_ashr();
    test_priority();
    test_zero();
    test_async_mid(8);
    test_async_mid(2);
    test_async_mid(64);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised WIDTH-bit universal register built from asynchronously reset D flip-flops. It supports hold, logical/arithmetic shift, rotate, parallel load and complement.
It is the general-purpose storage/shift element for the sequential-logic library and replaces per-bit flip-flops in counters, serialisers and LFSR-style datapaths.
It provides true and complement outputs, serial taps and a zero flag.

Parameters:
WIDTH, 8, register width in bits; legal range 2..64 (elaboration error otherwise).
RST_VAL, 0 (WIDTH bits), value loaded by rst and by sclr.

Ports:
clk  input  1  clock, rising-edge active.
rst  input  1  asynchronous, active-high reset.
en  input  1  clock enable; when 0, q holds (except for sclr).
sclr  input  1  synchronous clear to RST_VAL; ignores en.
mode  input  3  operation select (encoding below).
d  input  WIDTH  parallel load data.
ser_lsb_in  input  1  bit shifted into bit 0 on left shift.
ser_msb_in  input  1  bit shifted into bit WIDTH-1 on logical right shift.
q  output  WIDTH  register state.
qb  output  WIDTH  bitwise complement of q, combinational.
ser_msb_out  output  1  q[WIDTH-1], combinational.
ser_lsb_out  output  1  q[0], combinational.
zero  output  1  1 when q == 0, combinational.

Behaviour:
- Reset: rst=1 forces q=RST_VAL immediately, independent of clk.
  - While rst is asserted, qb=~RST_VAL, and zero/serial taps follow q.
  - After rst deasserts, the first update happens on the next rising clk edge.
- Priority at each rising edge: rst > sclr > en=0 (hold) > mode.
- sclr=1: q<=RST_VAL, regardless of en and mode.
- mode encoding, applied when en=1 and sclr=0:
  - 000 HOLD: q<=q.
  - 001 SHL: q<={q[W-2:0], ser_lsb_in}.
  - 010 SHR: q<={ser_msb_in, q[W-1:1]}.
  - 011 ROL: q<={q[W-2:0], q[W-1]}.
  - 100 ROR: q<={q[0], q[W-1:1]}.
  - 101 LOAD: q<=d.
  - 110 ASHR: q<={q[W-1], q[W-1:1]}; the sign bit is replicated.
  - 111 CPL: q<=~q.
- Latency: one clock from mode/d/serial input to q. qb, taps and zero follow q with no added register stage.
- Serial taps show the pre-shift value, so a downstream stage sampling ser_msb_out at the same edge as SHL captures the bit being shifted out.
- Wrap-around: ROL/ROR lose no bits; WIDTH consecutive rotates restore the original value.
- Inputs not used by the current mode are don't-care, and X on them must not propagate into q.
- Reset mid-operation: an async rst during any mode aborts it; no partial update is retained.
- rst deasserting at a clk edge: that edge is not required to update q; the bench avoids this window.
- No internal state other than q; no FSM beyond the mode decode.

Decomposition:
- Package usr_pkg holds:
  - localparam mode encodings MODE_HOLD..MODE_CPL (3-bit);
  - WIDTH_MIN=2 and WIDTH_MAX=64 constants.
- Natural sub-module usr_next: purely combinational next-state mux (mode, q, d, serial inputs -> nxt).
- The top level holds only the async-reset register, the sclr/en priority logic and the output assigns.

Test Plan:
1. Reset: WIDTH=8, RST_VAL=8'hA5, pulse rst between clk edges -> q=8'hA5 immediately, qb=8'h5A, zero=0.
2. Load and shift: LOAD d=8'h81, then SHL with ser_lsb_in=1 -> q=8'h03, and ser_msb_out=1 sampled before the edge; then SHR with ser_msb_in=0 -> q=8'h01.
3. Rotate and arithmetic shift:
   - LOAD 8'h96, then 8x ROL -> q=8'h96.
   - 8'h96 ROR -> 8'h4B.
   - LOAD 8'h90, ASHR -> 8'hC8, ASHR again -> 8'hE4.
4. Control priority:
   - q=8'h3C with en=0 and mode=CPL -> q stays 8'h3C.
   - en=1 -> q=8'hC3.
   - sclr=1 with en=0 -> q=RST_VAL.
   - sclr=1 and rst=1 together -> RST_VAL, async.
5. Zero flag: LOAD 8'h00 -> zero=1; SHL with ser_lsb_in=1 -> q=8'h01, zero=0.
6. Async reset mid-shift: rst asserted during a run of SHL -> q=RST_VAL without waiting for clk; after release, shifting resumes from RST_VAL. Repeat at WIDTH=2 and WIDTH=64.
